// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - EX-stage interface bundle for the multiply/divide unit
interface md_unit_if;
    logic        ex_valid;
    logic [2:0]  md_func;
    logic        md_sign;
    logic        hi_rd;
    logic        lo_rd;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    // Pipeline side: issues operations, observes status and HI/LO
    modport master (
        output ex_valid, md_func, md_sign, hi_rd, lo_rd, a, b,
        input  busy, md_stall, hi, lo
    );

    // Unit side
    modport slave (
        input  ex_valid, md_func, md_sign, hi_rd, lo_rd, a, b,
        output busy, md_stall, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - fixed-latency multiply/divide unit with HI/LO registers
module md_unit #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input logic       clk,
    input logic       reset,
    md_unit_if.slave  md
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    localparam logic [2:0] FN_MTHI = 3'd1;
    localparam logic [2:0] FN_MTLO = 3'd2;
    localparam logic [2:0] FN_MUL  = 3'd3;
    localparam logic [2:0] FN_DIV  = 3'd4;

    // Counter holds LAT-1 at most, so it only needs to represent MAX_LAT-1.
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [31:0]   a_q,     a_d;
    logic [31:0]   b_q,     b_d;
    logic          sign_q,  sign_d;
    logic [31:0]   hi_q,    hi_d;
    logic [31:0]   lo_q,    lo_d;

    logic        busy;
    logic        md_op;
    logic [63:0] mul_ea;
    logic [63:0] mul_eb;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_zero;

    // Status outputs: stall only instructions that touch HI/LO or start an op while busy
    always_comb begin
        busy  = (state_q != ST_IDLE);
        md_op = (md.md_func == FN_MTHI) || (md.md_func == FN_MTLO) ||
                (md.md_func == FN_MUL)  || (md.md_func == FN_DIV);
        md.busy     = busy;
        md.md_stall = busy && md.ex_valid && (md_op || md.hi_rd || md.lo_rd);
        md.hi       = hi_q;
        md.lo       = lo_q;
    end

    // Result datapath from the latched operands; low 64 bits of the
    // sign-extended product are correct for both signed and unsigned.
    // Signed divide goes through magnitudes so 0x80000000 / -1 wraps cleanly.
    always_comb begin
        mul_ea   = {{32{sign_q & a_q[31]}}, a_q};
        mul_eb   = {{32{sign_q & b_q[31]}}, b_q};
        prod     = mul_ea * mul_eb;
        a_neg    = sign_q & a_q[31];
        b_neg    = sign_q & b_q[31];
        a_mag    = a_neg ? (32'd0 - a_q) : a_q;
        b_mag    = b_neg ? (32'd0 - b_q) : b_q;
        div_zero = (b_q == 32'd0);
        q_mag    = div_zero ? 32'd0 : (a_mag / b_mag);
        r_mag    = div_zero ? 32'd0 : (a_mag % b_mag);
        quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem      = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    // Next-state: accept in IDLE, count down while busy, commit on the last busy cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (md.ex_valid) begin
                    case (md.md_func)
                        FN_MTHI: hi_d = md.a;
                        FN_MTLO: lo_d = md.a;
                        FN_MUL: begin
                            a_d     = md.a;
                            b_d     = md.b;
                            sign_d  = md.md_sign;
                            cnt_d   = MUL_CNT;
                            state_d = ST_MUL;
                        end
                        FN_DIV: begin
                            a_d     = md.a;
                            b_d     = md.b;
                            sign_d  = md.md_sign;
                            cnt_d   = DIV_CNT;
                            state_d = ST_DIV;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (cnt_q == '0) begin
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DIV: begin
                if (cnt_q == '0) begin
                    if (!div_zero) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset wins over any accept or pending commit
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed self-checking bench for md_unit
module tb_md_unit;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    md_unit_if mif ();

    md_unit #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] f, input logic s,
                         input logic hr, input logic lr,
                         input logic [31:0] ia, input logic [31:0] ib);
        mif.ex_valid = v;
        mif.md_func  = f;
        mif.md_sign  = s;
        mif.hi_rd    = hr;
        mif.lo_rd    = lr;
        mif.a        = ia;
        mif.b        = ib;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Issue a mul/div in the current cycle and follow it to completion.
    task automatic run_op(input string tag, input logic [2:0] f, input logic s,
                          input logic [31:0] ia, input logic [31:0] ib, input int lat,
                          input logic [31:0] eh, input logic [31:0] el);
        logic [31:0] oh;
        logic [31:0] ol;
        oh = mif.hi;
        ol = mif.lo;
        drive(1'b1, f, s, 1'b0, 1'b0, ia, ib);
        #1;
        check({tag, "_stall_T"}, {31'd0, mif.md_stall}, 32'd0);
        next();
        drive(1'b0, 3'd0, ~s, 1'b0, 1'b0, ~ia, ~ib);
        for (int k = 1; k <= lat; k++) begin
            #1;
            check({tag, "_busy"}, {31'd0, mif.busy}, 32'd1);
            check({tag, "_hold_hi"}, mif.hi, oh);
            check({tag, "_hold_lo"}, mif.lo, ol);
            next();
        end
        #1;
        check({tag, "_busy_end"}, {31'd0, mif.busy}, 32'd0);
        check({tag, "_hi"}, mif.hi, eh);
        check({tag, "_lo"}, mif.lo, el);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_hi", mif.hi, 32'd0);
        check("rst_lo", mif.lo, 32'd0);
        check("rst_busy", {31'd0, mif.busy}, 32'd0);
        check("rst_stall", {31'd0, mif.md_stall}, 32'd0);

        // Multiplies, including an immediate back-to-back issue
        run_op("mult_m3x5", 3'd3, 1'b1, 32'hFFFFFFFD, 32'd5, 5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("multu_max", 3'd3, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001);
        run_op("multu_b2b", 3'd3, 1'b0, 32'd3, 32'd4, 5, 32'h0, 32'hC);

        // Divides
        run_op("div_m7d2", 3'd4, 1'b1, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_ovf", 3'd4, 1'b1, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);

        // mthi/mtlo take effect next cycle without busy
        drive(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 32'h11, 32'd0);
        next();
        drive(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 32'h22, 32'd0);
        #1;
        check("mthi_hi", mif.hi, 32'h11);
        check("mthi_busy", {31'd0, mif.busy}, 32'd0);
        next();
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check("mtlo_lo", mif.lo, 32'h22);

        run_op("divu_by0", 3'd4, 1'b0, 32'd7, 32'd0, 10, 32'h11, 32'h22);
        run_op("div_7dm2", 3'd4, 1'b1, 32'd7, 32'hFFFFFFFE, 10, 32'h1, 32'hFFFFFFFD);

        // mflo presented at T+2 of a multiply stalls until results land
        drive(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 32'd6, 32'd7);
        next();
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        next();
        drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        for (int k = 2; k <= 5; k++) begin
            #1;
            check("mflo_stall", {31'd0, mif.md_stall}, 32'd1);
            check("mflo_old_lo", mif.lo, 32'hFFFFFFFD);
            next();
        end
        #1;
        check("mflo_stall_end", {31'd0, mif.md_stall}, 32'd0);
        check("mflo_new_lo", mif.lo, 32'h2A);
        next();
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        // mthi held by a multiply, then accepted once busy falls
        drive(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 32'd2, 32'd3);
        next();
        drive(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 32'h12345678, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            #1;
            check("mthi_wait_stall", {31'd0, mif.md_stall}, 32'd1);
            next();
        end
        #1;
        check("mthi_go_stall", {31'd0, mif.md_stall}, 32'd0);
        check("mthi_go_lo", mif.lo, 32'h6);
        check("mthi_go_hi", mif.hi, 32'h0);
        next();
        drive(1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 32'd9, 32'd1);
        #1;
        check("mthi_late_hi", mif.hi, 32'h12345678);
        check("mthi_late_busy", {31'd0, mif.busy}, 32'd0);

        // Invalid or no-op functions never change state
        next();
        drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'd1);
        #1;
        check("nov_div_busy", {31'd0, mif.busy}, 32'd0);
        next();
        drive(1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'd1);
        #1;
        check("func0_busy", {31'd0, mif.busy}, 32'd0);
        check("func0_hi", mif.hi, 32'h12345678);
        next();
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check("func7_busy", {31'd0, mif.busy}, 32'd0);
        check("func7_lo", mif.lo, 32'h6);

        // Reset at T+4 of a divide aborts it
        drive(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 32'd100, 32'd7);
        next();
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            #1;
            check("rdiv_busy", {31'd0, mif.busy}, 32'd1);
            next();
        end
        reset = 1'b1;
        next();
        reset = 1'b0;
        #1;
        check("rdiv_hi", mif.hi, 32'd0);
        check("rdiv_lo", mif.lo, 32'd0);
        check("rdiv_busy0", {31'd0, mif.busy}, 32'd0);
        repeat (8) next();
        check("rdiv_late_hi", mif.hi, 32'd0);
        check("rdiv_late_lo", mif.lo, 32'd0);

        // Reset beats a simultaneous accept
        drive(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 32'd5, 32'd5);
        reset = 1'b1;
        next();
        reset = 1'b0;
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check("racc_busy", {31'd0, mif.busy}, 32'd0);
        repeat (6) next();
        check("racc_lo", mif.lo, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
